// File: rtl/aes_result_serializer_pkg.sv
// Shared definitions for the AES result serializer.
//   state_t      : framing FSM states
//   FRAME_LEN    : bytes per result frame (header + 16 ct + 16 dt + status)
//   MATCH_BIT    : status byte bit carrying the match flag
//   TIMEOUT_BIT  : status byte bit carrying the timeout flag
//   msb_byte     : byte idx of a 128-bit word, counting from [127:120]
//   status_byte  : assembles the trailing status byte
package aes_result_pkg;

  typedef enum logic [2:0] {
    S_WAIT = 3'd0,
    S_HDR  = 3'd1,
    S_CT   = 3'd2,
    S_DT   = 3'd3,
    S_STAT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam int unsigned FRAME_LEN   = 34;
  localparam int unsigned MATCH_BIT   = 0;
  localparam int unsigned TIMEOUT_BIT = 1;

  function automatic logic [7:0] msb_byte(input logic [127:0] v, input logic [3:0] idx);
    logic [127:0] sh;
    sh = v << {idx, 3'b000};
    return sh[127:120];
  endfunction

  function automatic logic [7:0] status_byte(input logic m, input logic t);
    logic [7:0] b;
    b              = '0;
    b[MATCH_BIT]   = m;
    b[TIMEOUT_BIT] = t;
    return b;
  endfunction

endpackage

// File: rtl/aes_result_serializer_if.sv
// Byte-stream valid/ready channel towards the UART TX / debug sink.
//   tx_data  : frame byte (master -> slave)
//   tx_valid : tx_data valid (master -> slave)
//   tx_ready : sink accepts the byte (slave -> master)
interface aes_result_serializer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/aes_result_serializer_stable_detect.sv
// Decides when the decrypt output may be captured.
//   clk, rst_n     : clock, async active-low reset
//   i_clr          : synchronous clear of all history/counters (rearm)
//   i_en           : high while the framer waits for a result
//   i_dt           : decrypt result being watched
//   o_cap_pulse    : one-cycle capture strobe (stable or timed out)
//   o_cap_timeout  : qualifies o_cap_pulse as a forced (timeout) capture
module aes_stable_detect #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic [15:0] WAIT_MAX      = 16'd5000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [127:0] i_dt,
  output logic         o_cap_pulse,
  output logic         o_cap_timeout
);

  localparam logic [7:0]  STAB_SAT  = 8'(STABLE_CYCLES);
  localparam logic [7:0]  STAB_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST = WAIT_MAX - 16'd1;

  logic [127:0] r_prev_dt;
  logic [7:0]   r_stab_cnt;
  logic [15:0]  r_wait_cnt;
  logic         w_stable;
  logic         w_norm;
  logic         w_force;

  assign w_stable = (i_dt != '0) && (i_dt == r_prev_dt);
  assign w_norm   = i_en && w_stable && (r_stab_cnt == STAB_LAST);
  // A stable capture takes priority over a timeout landing on the same cycle.
  assign w_force  = i_en && (r_wait_cnt == WAIT_LAST) && !w_norm;

  assign o_cap_pulse   = w_norm || w_force;
  assign o_cap_timeout = w_force;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_dt  <= '0;
      r_stab_cnt <= '0;
      r_wait_cnt <= '0;
    end else if (i_clr) begin
      r_prev_dt  <= '0;
      r_stab_cnt <= '0;
      r_wait_cnt <= '0;
    end else if (i_en) begin
      r_prev_dt  <= i_dt;
      r_wait_cnt <= r_wait_cnt + 16'd1;
      if (!w_stable)
        r_stab_cnt <= '0;
      else if (r_stab_cnt != STAB_SAT)
        r_stab_cnt <= r_stab_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/aes_result_serializer.sv
// Captures the AES encrypt/decrypt results, checks the decrypt result
// against the plaintext and streams a 34-byte result frame:
//   A5 | ct[127:120]..ct[7:0] | dt[127:120]..dt[7:0] | {6'b0,timeout,match}
//   clk, rst_n      : clock, async active-low reset
//   ciphertext      : encrypt result
//   decrypted_text  : decrypt result (watched for stability)
//   plaintext       : reference for the match check
//   rearm           : pulse in the done state to start a new capture
//   tx              : valid/ready byte channel (master side)
//   done            : frame fully sent, held until rearm/reset
//   match           : captured decrypt equals captured plaintext
//   timeout         : capture was forced by the wait limit
module aes_result_serializer
  import aes_result_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic [15:0] WAIT_MAX      = 16'd5000,
  parameter logic [7:0]  HDR_BYTE      = 8'hA5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [127:0]              ciphertext,
  input  logic [127:0]              decrypted_text,
  input  logic [127:0]              plaintext,
  input  logic                      rearm,
  aes_result_serializer_if.master   tx,
  output logic                      done,
  output logic                      match,
  output logic                      timeout
);

  // Bytes per captured block: frame minus header and status, split in two.
  localparam int unsigned BLOCK_BYTES = (FRAME_LEN - 2) / 2;
  localparam logic [3:0]  LAST_IDX    = 4'(BLOCK_BYTES - 1);

  state_t       r_state;
  state_t       w_next;
  logic [3:0]   r_idx;
  logic [127:0] r_ct;
  logic [127:0] r_dt;
  logic         r_match;
  logic         r_timeout;
  logic         w_cap;
  logic         w_cap_to;
  logic         w_xfer;
  logic         w_rearm;
  logic         w_in_wait;

  assign w_in_wait = (r_state == S_WAIT);
  assign w_rearm   = rearm && (r_state == S_DONE);
  assign w_xfer    = tx.tx_valid && tx.tx_ready;

  aes_stable_detect #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .WAIT_MAX      (WAIT_MAX)
  ) u_stable_detect (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clr         (w_rearm),
    .i_en          (w_in_wait),
    .i_dt          (decrypted_text),
    .o_cap_pulse   (w_cap),
    .o_cap_timeout (w_cap_to)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_WAIT;
    else        r_state <= w_next;
  end

  // tx_data/tx_valid are decoded from registered state only, so they hold
  // steady during a stall and drop to zero the instant reset asserts.
  always_comb begin
    w_next      = r_state;
    tx.tx_valid = 1'b0;
    tx.tx_data  = '0;
    done        = 1'b0;
    case (r_state)
      S_WAIT: if (w_cap) w_next = S_HDR;
      S_HDR: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = HDR_BYTE;
        if (w_xfer) w_next = S_CT;
      end
      S_CT: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = msb_byte(r_ct, r_idx);
        if (w_xfer && r_idx == LAST_IDX) w_next = S_DT;
      end
      S_DT: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = msb_byte(r_dt, r_idx);
        if (w_xfer && r_idx == LAST_IDX) w_next = S_STAT;
      end
      S_STAT: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = status_byte(r_match, r_timeout);
        if (w_xfer) w_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (rearm) w_next = S_WAIT;
      end
      default: w_next = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_ct      <= '0;
      r_dt      <= '0;
      r_match   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_in_wait && w_cap) begin
        r_ct      <= ciphertext;
        r_dt      <= decrypted_text;
        r_match   <= (decrypted_text == plaintext);
        r_timeout <= w_cap_to;
        r_idx     <= '0;
      end
      // 4-bit index wraps 15->0 naturally on each block boundary.
      if (w_xfer && (r_state == S_CT || r_state == S_DT))
        r_idx <= r_idx + 4'd1;
      if (w_rearm) begin
        r_match   <= 1'b0;
        r_timeout <= 1'b0;
        r_idx     <= '0;
      end
    end
  end

  assign match   = r_match;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_aes_result_serializer.sv
module tb_aes_result_serializer;

  localparam int          STABLE = 4;
  localparam int          WMAX   = 5000;
  localparam logic [7:0]  HDR    = 8'hA5;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] ct, dt, pt;
  logic         rearm;
  logic         done, match, timeout;

  aes_result_serializer_if tx_if();

  aes_result_serializer #(
    .STABLE_CYCLES (STABLE),
    .WAIT_MAX      (16'(WMAX)),
    .HDR_BYTE      (HDR)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ciphertext     (ct),
    .decrypted_text (dt),
    .plaintext      (pt),
    .rearm          (rearm),
    .tx             (tx_if.master),
    .done           (done),
    .match          (match),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;
  logic [127:0] dt_seq[$];
  logic [7:0]   rx[$];
  logic [7:0]   exp_q[$];
  bit           prev_stall = 1'b0;
  logic [7:0]   prev_data  = '0;

  typedef struct {
    string        name;
    logic [127:0] p, c, d, alt;
    int           zeros;
    bit           toggle;
    int           rmode;
    int           exp_cap;
    logic         exp_m, exp_to;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Value of decrypted_text in wait cycle t; history before the wait is zero.
  function automatic logic [127:0] seq_at(input int t);
    if (t < 0) return '0;
    if (t >= dt_seq.size()) return dt_seq[dt_seq.size()-1];
    return dt_seq[t];
  endfunction

  // Capture is legal in cycle t when the last STABLE+1 samples are equal and non-zero.
  function automatic bit window_ok(input int t);
    logic [127:0] v;
    v = seq_at(t);
    if (v == '0) return 1'b0;
    for (int j = 1; j <= STABLE; j++)
      if (seq_at(t - j) != v) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int predict_cap();
    for (int t = 0; t < WMAX; t++)
      if (window_ok(t)) return t;
    return WMAX - 1;
  endfunction

  task automatic build_exp(input logic [127:0] c, input logic [127:0] d,
                           input logic m, input logic to);
    exp_q.delete();
    exp_q.push_back(HDR);
    for (int i = 0; i < 16; i++) exp_q.push_back(c[127-8*i -: 8]);
    for (int i = 0; i < 16; i++) exp_q.push_back(d[127-8*i -: 8]);
    exp_q.push_back({6'b0, to, m});
  endtask

  // One clock cycle: checks stall holding, logs transfers, advances to #1 after the edge.
  task automatic step();
    if (prev_stall) begin
      chk("stall_valid_hold", 128'(tx_if.tx_valid), 128'(1'b1));
      chk("stall_data_hold", 128'(tx_if.tx_data), 128'(prev_data));
    end
    if (tx_if.tx_valid && tx_if.tx_ready) rx.push_back(tx_if.tx_data);
    prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
    prev_data  = tx_if.tx_data;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string nm, input logic [127:0] p, input logic [127:0] c,
                           input int rmode, input int exp_cap,
                           input logic exp_m, input logic exp_to, input bit abort10);
    int          w;
    int          k;
    int          cap_w;
    logic [3:0]  pat;
    pat   = 4'b1001;
    cap_w = -1;
    w     = 0;
    rx.delete();
    while (cap_w < 0 && w < WMAX + 20) begin
      pt = p; ct = c; dt = seq_at(w);
      tx_if.tx_ready = 1'($urandom % 2);
      rearm = (rmode == 2) ? ($urandom % 8 == 0) : 1'b0;
      step();
      if (tx_if.tx_valid) cap_w = w;
      w++;
    end
    rearm = 1'b0;
    chk({nm, " capture_cycle"}, 128'(cap_w), 128'(exp_cap));
    if (cap_w < 0) return;
    chk({nm, " done_low_in_frame"}, 128'(done), 128'(1'b0));
    build_exp(c, seq_at(exp_cap), exp_m, exp_to);

    k = 0;
    while (!done && k < 400) begin
      case (rmode)
        0:       tx_if.tx_ready = 1'b1;
        1:       tx_if.tx_ready = pat[3 - (k % 4)];
        default: tx_if.tx_ready = ($urandom % 3 != 0);
      endcase
      if (rmode == 2) rearm = ($urandom % 6 == 0);
      pt = rnd128(); ct = rnd128(); dt = rnd128();
      if (abort10 && rx.size() == 10) begin
        rst_n = 1'b0;
        #1;
        chk({nm, " reset_valid"}, 128'(tx_if.tx_valid), 128'(1'b0));
        chk({nm, " reset_data"}, 128'(tx_if.tx_data), 128'(8'h00));
        chk({nm, " reset_done"}, 128'(done), 128'(1'b0));
        chk({nm, " reset_match"}, 128'(match), 128'(1'b0));
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        prev_stall = 1'b0;
        rearm      = 1'b0;
        return;
      end
      step();
      k++;
    end
    rearm = 1'b0;
    chk({nm, " done"}, 128'(done), 128'(1'b1));
    chk({nm, " byte_count"}, 128'(rx.size()), 128'(34));
    for (int i = 0; i < 34; i++)
      if (i < rx.size()) chk($sformatf("%s byte%0d", nm, i), 128'(rx[i]), 128'(exp_q[i]));
    chk({nm, " match"}, 128'(match), 128'(exp_m));
    chk({nm, " timeout"}, 128'(timeout), 128'(exp_to));
    if (rmode == 0) chk({nm, " latency"}, 128'(k), 128'(34));

    for (int i = 0; i < 3; i++) begin
      pt = rnd128(); ct = rnd128(); dt = rnd128();
      tx_if.tx_ready = 1'($urandom % 2);
      step();
      chk({nm, " idle_valid"}, 128'(tx_if.tx_valid), 128'(1'b0));
      chk({nm, " idle_done"}, 128'(done), 128'(1'b1));
      chk({nm, " idle_flags"}, 128'({timeout, match}), 128'({exp_to, exp_m}));
    end
    rearm = 1'b1;
    step();
    rearm = 1'b0;
    chk({nm, " rearm_clear"}, 128'({done, match, timeout, tx_if.tx_valid}), 128'(4'b0000));
  endtask

  task automatic build_seq(input vec_t v);
    dt_seq.delete();
    if (v.toggle) begin
      for (int w = 0; w < 50; w++) dt_seq.push_back(((w / 2) % 2 == 0) ? v.alt : v.d);
    end else begin
      for (int w = 0; w < v.zeros; w++) dt_seq.push_back('0);
    end
    dt_seq.push_back(v.d);
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{"fips",     FIPS_PT, FIPS_CT, FIPS_PT, '0, 20, 1'b0, 0, 24,   1'b1, 1'b0};
    tbl[1] = '{"mismatch", FIPS_PT, FIPS_CT, 128'h00112233445566778899aabbccddeefe, '0,
               0, 1'b0, 0, 4, 1'b0, 1'b0};
    tbl[2] = '{"timeout",  FIPS_PT, FIPS_CT, '0, '0, 0, 1'b0, 0, WMAX-1, 1'b0, 1'b1};
    tbl[3] = '{"unstable", FIPS_PT, FIPS_CT, FIPS_PT, {4{32'h13572468}}, 0, 1'b1, 0, 54,
               1'b1, 1'b0};
    tbl[4] = '{"backpressure", FIPS_PT, FIPS_CT, FIPS_PT, '0, 20, 1'b0, 1, 24, 1'b1, 1'b0};

    rst_n = 1'b0; rearm = 1'b0;
    pt = '0; ct = '0; dt = '0;
    tx_if.tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 128'(tx_if.tx_valid), 128'(1'b0));
    chk("reset_data", 128'(tx_if.tx_data), 128'(8'h00));
    chk("reset_flags", 128'({done, match, timeout}), 128'(3'b000));
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      build_seq(tbl[i]);
      run_frame(tbl[i].name, tbl[i].p, tbl[i].c, tbl[i].rmode, tbl[i].exp_cap,
                tbl[i].exp_m, tbl[i].exp_to, 1'b0);
    end

    build_seq(tbl[0]);
    run_frame("reset_mid_frame", FIPS_PT, FIPS_CT, 0, 24, 1'b1, 1'b0, 1'b1);
    run_frame("after_reset", FIPS_PT, FIPS_CT, 0, 24, 1'b1, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      logic [127:0] p, c, alt, hold;
      int           len, cap;
      p    = rnd128() | 128'h1;
      c    = rnd128();
      alt  = rnd128() | 128'h2;
      hold = ($urandom % 2) ? p : alt;
      len  = $urandom_range(0, 30);
      dt_seq.delete();
      for (int w = 0; w < len; w++) begin
        case ($urandom % 3)
          0:       dt_seq.push_back('0);
          1:       dt_seq.push_back(p);
          default: dt_seq.push_back(alt);
        endcase
      end
      dt_seq.push_back(hold);
      cap = predict_cap();
      run_frame($sformatf("random%0d", r), p, c, 2, cap,
                seq_at(cap) == p, !window_ok(cap), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected end before time limit");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/aes_result_serializer.md
Name: aes_result_serializer

Overview:
- Downstream consumer of the AES encrypt/decrypt top level.
- Watches `ciphertext` and `decrypted_text`, and captures both once the decrypt output is non-zero and stable, or once a timeout expires.
- Compares the captured decrypt result against `plaintext`.
- Streams a fixed 34-byte result frame over a valid/ready byte interface that feeds the UART TX / debug channel.

Parameters:
- STABLE_CYCLES, 4: consecutive cycles `decrypted_text` must be non-zero and unchanged before capture (legal 1..255).
- WAIT_MAX, 16'd5000: cycles in S_WAIT before a forced capture with the timeout flag set.
- HDR_BYTE, 8'hA5: first byte of every frame.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ciphertext  input  128  encrypt result from upstream.
- decrypted_text  input  128  decrypt result from upstream.
- plaintext  input  128  original plaintext, used for the match check.
- rearm  input  1  single-cycle pulse; restarts capture from S_DONE.
- tx_data  output  8  frame byte.
- tx_valid  output  1  `tx_data` is valid.
- tx_ready  input  1  sink accepts the byte.
- done  output  1  frame fully sent; stays high until rearm or reset.
- match  output  1  captured decrypt equals captured plaintext.
- timeout  output  1  capture was forced by WAIT_MAX.

Behaviour:
- Reset (async, rst_n low), effective immediately, including mid-frame:
  - state = S_WAIT.
  - tx_valid = 0, tx_data = 0.
  - done, match, timeout = 0.
  - All capture registers and counters = 0.
- State sequence: S_WAIT -> S_HDR -> S_CT -> S_DT -> S_STAT -> S_DONE.
- S_WAIT:
  - `prev_dt` registers `decrypted_text` every cycle.
  - `stab_cnt` increments when `decrypted_text != 0` and `decrypted_text == prev_dt`, saturating at STABLE_CYCLES. Otherwise `stab_cnt` clears.
  - `wait_cnt` (16-bit) increments every cycle.
  - Normal capture: on the cycle where `stab_cnt == STABLE_CYCLES-1` and the stability condition still holds:
    - ct_q <= ciphertext, dt_q <= decrypted_text, pt_q <= plaintext.
    - timeout <= 0.
  - Forced capture: if `wait_cnt == WAIT_MAX-1` and there is no normal capture that cycle, capture the same registers and set timeout <= 1.
  - A normal capture wins if both conditions hit in the same cycle.
  - After either capture: match <= (decrypted_text == plaintext), computed on the inputs in the capture cycle. Go to S_HDR.
- Frame content:
  - S_HDR: HDR_BYTE.
  - S_CT: 16 bytes of ct_q, [127:120] first.
  - S_DT: 16 bytes of dt_q, [127:120] first.
  - S_STAT: status byte {6'b0, timeout, match}.
- Frame timing and counters:
  - tx_valid rises in the cycle after capture.
  - A byte transfers when tx_valid && tx_ready.
  - A 4-bit byte index advances only on a transfer. It wraps 15 -> 0 on the move from S_CT to S_DT and from S_DT to S_STAT.
  - Frame length is exactly 34 transfers.
  - Minimum latency from capture to `done` is 35 cycles with tx_ready held high.
- Handshake rules:
  - While tx_valid && !tx_ready, tx_data and tx_valid hold unchanged.
  - tx_valid never drops without a transfer.
  - Back-to-back transfers are allowed, one byte per cycle.
- S_DONE:
  - tx_valid = 0, done = 1.
  - match and timeout hold.
  - Upstream input changes are ignored.
  - rearm -> S_WAIT, clearing done, match, timeout and all counters.
  - rearm in any other state is ignored.
- Captured registers never change between capture and rearm.
- Inputs changing mid-frame do not alter the frame.

Decomposition:
- Package `aes_result_pkg`:
  - State encoding: 3-bit localparams S_WAIT..S_DONE.
  - FRAME_LEN = 34.
  - Status bit positions: MATCH_BIT = 0, TIMEOUT_BIT = 1.
- One sub-module, `aes_stable_detect`:
  - Contains prev_dt, stab_cnt, wait_cnt.
  - Outputs a one-cycle `cap_pulse` and `cap_timeout`.
  - Has a `clr` input, driven by rearm.
- Framing FSM and byte mux stay in the top of this block.

Test Plan:
1. FIPS-197 vector, tx_ready = 1 throughout:
   - Stimulus: plaintext = 00112233445566778899aabbccddeeff; ciphertext = 69c4e0d86a7b0430d8cdb78070b4c55a; decrypted_text = 0 for 20 cycles, then = plaintext.
   - Required: capture 4 cycles after decrypted_text becomes non-zero.
   - Required frame: A5, 69 c4 … 5a, 00 11 … ff, 01.
   - Required: done = 1, match = 1, timeout = 0.
2. Mismatch:
   - Stimulus: decrypted_text = 00112233445566778899aabbccddeefe, stable.
   - Required: status byte 00, match = 0.
3. Timeout:
   - Stimulus: decrypted_text held at 0.
   - Required: capture at cycle 5000; status byte 02 (timeout = 1, match = 0); frame carries zero dt bytes.
4. Instability:
   - Stimulus: decrypted_text toggles between two non-zero values every 2 cycles for 50 cycles, then holds.
   - Required: no capture until 4 stable cycles after the hold.
5. Backpressure:
   - Stimulus: tx_ready pattern 1,0,0,1 repeated.
   - Required: every held byte stable while stalled; exactly 34 transfers; byte order unchanged.
6. Reset and rearm:
   - Stimulus: rst_n pulsed low during byte 10.
   - Required: tx_valid = 0 immediately; FSM back in S_WAIT.
   - Stimulus: rearm pulsed in S_DONE.
   - Required: a second full frame with fresh capture; done low during it.
